hd44780_ctrl: RTL and testbench

Parametrised HD44780 character-LCD controller, the next generation of our fixed-sequence LCD driver. It runs the datasheet power-on initialisation autonomously in 8-bit or 4-bit bus mode, then accepts command/data bytes over a valid/ready handshake. It generates correctly timed RS/EN/DB waveforms derived from the clock frequency, and waits out each instruction's execution time. It sits between the display-content logic (text buffer/scroller) and the board LCD pins.

---
 rtl/hd44780_pkg.sv | 45 ++++
 rtl/hd44780_init_rom.sv | 52 +++++
 rtl/hd44780_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_hd44780_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 character-LCD controller:
// FSM state encodings, init-table delay selectors, instruction bytes
// and the clock-cycle conversion used to derive every bus/exec delay.
package hd44780_pkg;

  // FSM state encodings, kept as fixed 3-bit codes for legacy tooling
  typedef logic [2:0] state_t;
  localparam state_t ST_PWR_WAIT  = 3'd0;
  localparam state_t ST_INIT_LOAD = 3'd1;
  localparam state_t ST_SETUP     = 3'd2;
  localparam state_t ST_EN_HI     = 3'd3;
  localparam state_t ST_HOLD      = 3'd4;
  localparam state_t ST_NIB_GAP   = 3'd5;
  localparam state_t ST_EXEC_WAIT = 3'd6;
  localparam state_t ST_IDLE      = 3'd7;

  // Post-strobe wait selected by an init-table entry
  typedef enum logic [1:0] {
    DLY_EXEC   = 2'd0,
    DLY_LONG   = 2'd1,
    DLY_4100US = 2'd2,
    DLY_100US  = 2'd3
  } dly_sel_t;

  // Instruction bytes
  localparam logic [7:0] INS_CLEAR    = 8'h01;
  localparam logic [7:0] INS_HOME     = 8'h02;
  localparam logic [7:0] INS_FUNC_8B  = 8'h38;
  localparam logic [7:0] INS_FUNC_4B  = 8'h28;
  localparam logic [7:0] INS_DISP_OFF = 8'h08;
  localparam logic [7:0] INS_WAKE_8B  = 8'h30;
  localparam logic [7:0] INS_WAKE_4B  = 8'h20;

  localparam int unsigned INIT_IDX_W = 4;

  // Cycles needed to cover t_ns at clk_hz, rounded up, never below one
  function automatic int unsigned cyc(input longint unsigned clk_hz,
                                      input longint unsigned t_ns);
    longint unsigned c;
    c = (clk_hz * t_ns + 64'd999_999_999) / 64'd1_000_000_000;
    if (c == 64'd0) c = 64'd1;
    return c[31:0];
  endfunction

endpackage

// File: rtl/hd44780_init_rom.sv
// Power-on initialisation table for the HD44780. Maps a step index to
// the byte to send, whether it is a single high-nibble strobe, which
// wait follows it, and whether it is the final step.
module hd44780_init_rom
  import hd44780_pkg::*;
#(
  parameter int unsigned BUS_4BIT   = 0,
  parameter logic [7:0]  ENTRY_MODE = 8'h06,
  parameter logic [7:0]  DISP_CTRL  = 8'h0C
) (
  input  logic [INIT_IDX_W-1:0] idx,
  output logic [7:0]            step_byte,
  output logic                  nibble_only,
  output logic [1:0]            delay_sel,
  output logic                  last
);

  // Table lookup; 4-bit mode starts with four wake-up nibbles
  always_comb begin
    step_byte   = '0;
    nibble_only = 1'b0;
    delay_sel   = DLY_EXEC;
    last        = 1'b0;
    if (BUS_4BIT != 0) begin
      case (idx)
        4'd0: begin step_byte = INS_WAKE_8B; nibble_only = 1'b1; delay_sel = DLY_4100US; end
        4'd1: begin step_byte = INS_WAKE_8B; nibble_only = 1'b1; delay_sel = DLY_100US;  end
        4'd2: begin step_byte = INS_WAKE_8B; nibble_only = 1'b1; end
        4'd3: begin step_byte = INS_WAKE_4B; nibble_only = 1'b1; end
        4'd4: step_byte = INS_FUNC_4B;
        4'd5: step_byte = INS_DISP_OFF;
        4'd6: begin step_byte = INS_CLEAR; delay_sel = DLY_LONG; end
        4'd7: step_byte = ENTRY_MODE;
        4'd8: begin step_byte = DISP_CTRL; last = 1'b1; end
        default: last = 1'b1;
      endcase
    end else begin
      case (idx)
        4'd0: begin step_byte = INS_WAKE_8B; delay_sel = DLY_4100US; end
        4'd1: begin step_byte = INS_WAKE_8B; delay_sel = DLY_100US;  end
        4'd2: step_byte = INS_WAKE_8B;
        4'd3: step_byte = INS_FUNC_8B;
        4'd4: step_byte = INS_DISP_OFF;
        4'd5: begin step_byte = INS_CLEAR; delay_sel = DLY_LONG; end
        4'd6: step_byte = ENTRY_MODE;
        4'd7: begin step_byte = DISP_CTRL; last = 1'b1; end
        default: last = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/hd44780_ctrl.sv
// HD44780 character-LCD controller. Runs the power-on init sequence in
// 8-bit or 4-bit bus mode, then writes host command/data bytes taken
// over a valid/ready handshake, generating timed RS/EN/DB waveforms and
// waiting out each instruction's execution time.
module hd44780_ctrl
  import hd44780_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BUS_4BIT   = 0,
  parameter logic [7:0]  DISP_CTRL  = 8'h0C,
  parameter logic [7:0]  ENTRY_MODE = 8'h06
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  input  logic       bl_on,
  output logic       init_done,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_blon
);

  localparam int unsigned C_SETUP = cyc(64'(CLK_HZ), 64'd60);
  localparam int unsigned C_EN    = cyc(64'(CLK_HZ), 64'd450);
  localparam int unsigned C_HOLD  = cyc(64'(CLK_HZ), 64'd20);
  localparam int unsigned C_NIB   = cyc(64'(CLK_HZ), 64'd1_000);
  localparam int unsigned C_EXEC  = cyc(64'(CLK_HZ), 64'd40_000);
  localparam int unsigned C_LONG  = cyc(64'(CLK_HZ), 64'd1_640_000);
  localparam int unsigned C_4100  = cyc(64'(CLK_HZ), 64'd4_100_000);
  localparam int unsigned C_100   = cyc(64'(CLK_HZ), 64'd100_000);
  localparam int unsigned C_PWR   = cyc(64'(CLK_HZ), 64'd15_000_000);
  localparam int unsigned CNT_W   = $clog2(C_PWR + 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        exec_load;
  logic [INIT_IDX_W-1:0]   idx;
  logic [7:0]              cur_byte;
  logic                    cur_rs;
  logic                    cur_nib_only;
  dly_sel_t                cur_dsel;
  logic                    cur_last;
  logic                    lo_phase;
  logic                    split_byte;

  logic [7:0]              rom_byte;
  logic                    rom_nib;
  logic [1:0]              rom_dsel;
  logic                    rom_last;

  hd44780_init_rom #(
    .BUS_4BIT  (BUS_4BIT),
    .ENTRY_MODE(ENTRY_MODE),
    .DISP_CTRL (DISP_CTRL)
  ) u_init_rom (
    .idx        (idx),
    .step_byte  (rom_byte),
    .nibble_only(rom_nib),
    .delay_sel  (rom_dsel),
    .last       (rom_last)
  );

  // First strobe of a byte: whole byte in 8-bit mode, high nibble in 4-bit
  function automatic logic [7:0] hi_bus(input logic [7:0] b);
    return (BUS_4BIT != 0) ? {b[7:4], 4'h0} : b;
  endfunction

  assign cmd_ready  = (state == ST_IDLE);
  assign lcd_rw     = 1'b0;
  assign split_byte = (BUS_4BIT != 0) && !cur_nib_only && !lo_phase;

  // Execution wait after the final strobe; clear/home always need the long wait
  always_comb begin
    exec_load = CNT_W'(C_EXEC - 1);
    if (!cur_rs && (cur_byte inside {8'h01, 8'h02, 8'h03})) begin
      exec_load = CNT_W'(C_LONG - 1);
    end else begin
      case (cur_dsel)
        DLY_LONG:   exec_load = CNT_W'(C_LONG - 1);
        DLY_4100US: exec_load = CNT_W'(C_4100 - 1);
        DLY_100US:  exec_load = CNT_W'(C_100 - 1);
        default:    exec_load = CNT_W'(C_EXEC - 1);
      endcase
    end
  end

  // Backlight request, registered straight through
  always_ff @(posedge clk) begin
    if (rst) lcd_blon <= 1'b0;
    else     lcd_blon <= bl_on;
  end

  // Sequencer: power wait, init table walk, strobe timing, host writes.
  // Each timed state loads cnt with (length-1) and leaves when it hits 0;
  // a host write loads one extra SETUP cycle so the bus settles a full
  // SETUP period after the cycle it is first registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_PWR_WAIT;
      cnt          <= CNT_W'(C_PWR - 1);
      idx          <= '0;
      init_done    <= 1'b0;
      lcd_en       <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_db       <= '0;
      cur_byte     <= '0;
      cur_rs       <= 1'b0;
      cur_nib_only <= 1'b0;
      cur_dsel     <= DLY_EXEC;
      cur_last     <= 1'b0;
      lo_phase     <= 1'b0;
    end else begin
      case (state)
        ST_PWR_WAIT: begin
          if (cnt == '0) state <= ST_INIT_LOAD;
          else           cnt   <= cnt - 1'b1;
        end
        ST_INIT_LOAD: begin
          cur_byte     <= rom_byte;
          cur_rs       <= 1'b0;
          cur_nib_only <= rom_nib;
          cur_dsel     <= dly_sel_t'(rom_dsel);
          cur_last     <= rom_last;
          lo_phase     <= 1'b0;
          lcd_rs       <= 1'b0;
          lcd_db       <= hi_bus(rom_byte);
          cnt          <= CNT_W'(C_SETUP - 1);
          state        <= ST_SETUP;
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= CNT_W'(C_EN - 1);
            state  <= ST_EN_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_EN_HI: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= CNT_W'(C_HOLD - 1);
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            if (split_byte) begin
              cnt   <= CNT_W'(C_NIB - 1);
              state <= ST_NIB_GAP;
            end else begin
              cnt   <= exec_load;
              state <= ST_EXEC_WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_NIB_GAP: begin
          if (cnt == '0) begin
            lo_phase <= 1'b1;
            lcd_db   <= {cur_byte[3:0], 4'h0};
            cnt      <= CNT_W'(C_SETUP - 1);
            state    <= ST_SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_EXEC_WAIT: begin
          if (cnt == '0) begin
            if (init_done) begin
              state <= ST_IDLE;
            end else if (cur_last) begin
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_INIT_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            cur_byte     <= cmd_data;
            cur_rs       <= cmd_rs;
            cur_nib_only <= 1'b0;
            cur_dsel     <= DLY_EXEC;
            cur_last     <= 1'b0;
            lo_phase     <= 1'b0;
            lcd_rs       <= cmd_rs;
            lcd_db       <= hi_bus(cmd_data);
            cnt          <= CNT_W'(C_SETUP);
            state        <= ST_SETUP;
          end
        end
        default: begin
          lcd_en <= 1'b0;
          cnt    <= CNT_W'(C_PWR - 1);
          state  <= ST_PWR_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Directed bench for hd44780_ctrl at CLK_HZ = 1 MHz (1 cycle = 1 us):
// one 8-bit instance and one 4-bit instance, exercised in turn.
module tb_hd44780_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1;
  logic       rst4 = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       bl_on = 1'b0;
  logic       sel4 = 1'b0;

  logic       rdy8, done8, rs8, rw8, en8, blon8;
  logic       rdy4, done4, rs4, rw4, en4, blon4;
  logic [7:0] db8, db4;

  hd44780_ctrl #(
    .CLK_HZ(1_000_000), .BUS_4BIT(0), .DISP_CTRL(8'h0C), .ENTRY_MODE(8'h06)
  ) dut8 (
    .clk(clk), .rst(rst8), .cmd_valid(cmd_valid), .cmd_ready(rdy8),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .bl_on(bl_on), .init_done(done8),
    .lcd_db(db8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_en(en8), .lcd_blon(blon8)
  );

  hd44780_ctrl #(
    .CLK_HZ(1_000_000), .BUS_4BIT(1), .DISP_CTRL(8'h0C), .ENTRY_MODE(8'h06)
  ) dut4 (
    .clk(clk), .rst(rst4), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .bl_on(bl_on), .init_done(done4),
    .lcd_db(db4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_en(en4), .lcd_blon(blon4)
  );

  logic [7:0] db;
  logic       en, rs, rw, rdy, done, blon;
  assign db   = sel4 ? db4   : db8;
  assign en   = sel4 ? en4   : en8;
  assign rs   = sel4 ? rs4   : rs8;
  assign rw   = sel4 ? rw4   : rw8;
  assign rdy  = sel4 ? rdy4  : rdy8;
  assign done = sel4 ? done4 : done8;
  assign blon = sel4 ? blon4 : blon8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input int limit, output int n);
    n = 0;
    while (en !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rdy(input int limit, output int n);
    n = 0;
    while (rdy !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Issue one write from IDLE and watch it until ready returns
  task automatic do_cmd(input logic r, input logic [7:0] d,
                        output int lat, output int nstb,
                        output logic [7:0] db_a, output logic [7:0] db_b,
                        output int gap, output logic low_seen, output logic rs_a);
    int k;
    int t1;
    cmd_rs = r;
    cmd_data = d;
    cmd_valid = 1'b1;
    tick();
    k = cyc;
    cmd_valid = 1'b0;
    nstb = 0; db_a = '0; db_b = '0; gap = 0; low_seen = 1'b0; rs_a = 1'b0; t1 = 0;
    while (rdy !== 1'b1 && (cyc - k) < 3000) begin
      tick();
      if (db[3:0] !== 4'h0) low_seen = 1'b1;
      if (en === 1'b1) begin
        nstb++;
        if (nstb == 1) begin
          db_a = db; rs_a = rs; t1 = cyc;
        end else if (nstb == 2) begin
          db_b = db; gap = cyc - t1;
        end
      end
    end
    lat = cyc - k;
  endtask

  logic [7:0] exp8 [5] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic [3:0] exp4 [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0,
                            4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};

  initial begin
    int n, k, t0, lat, nstb, gap;
    logic seen;
    logic low_seen, rs_a;
    logic [7:0] db_a, db_b;

    // ---------------- 8-bit instance ----------------
    bl_on = 1'b1;
    repeat (3) tick();
    chk("rst_en",    en,   1'b0);
    chk("rst_rs",    rs,   1'b0);
    chk("rst_rw",    rw,   1'b0);
    chk("rst_db",    db,   8'h00);
    chk("rst_blon",  blon, 1'b0);
    chk("rst_ready", rdy,  1'b0);
    chk("rst_done",  done, 1'b0);

    rst8 = 1'b0;
    tick();
    chk("blon_reg", blon, 1'b1);
    seen = en;
    repeat (14999) begin
      tick();
      if (en === 1'b1) seen = 1'b1;
    end
    chk("pwr_quiet", seen, 1'b0);
    wait_en(10, n);
    chk("pwr_first_strobe_due", (n >= 1 && n <= 3), 1'b1);
    chk("init0_db", db, 8'h30);
    chk("init0_rs", rs, 1'b0);
    t0 = cyc;
    tick();
    chk("en_width", en, 1'b0);

    wait_en(5000, n);
    chk("init1_db", db, 8'h30);
    chk("gap_4100us", ((cyc - t0) >= 4100 && (cyc - t0) <= 4110), 1'b1);
    t0 = cyc;
    tick();
    wait_en(500, n);
    chk("init2_db", db, 8'h30);
    chk("gap_100us", ((cyc - t0) >= 100 && (cyc - t0) <= 110), 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      wait_en(2000, n);
      chk($sformatf("init%0d_db", i + 3), db, exp8[i]);
      if (i == 3) chk("gap_after_clear", ((cyc - t0) >= 1640 && (cyc - t0) <= 1650), 1'b1);
      if (i == 4) chk("done_before_last", done, 1'b0);
      t0 = cyc;
      tick();
    end
    wait_rdy(100, n);
    chk("init_ready_latency", cyc - t0, 42);
    chk("init_done", done, 1'b1);

    // Data write 0x41, cmd_valid held through the busy period
    cmd_rs = 1'b1; cmd_data = 8'h41; cmd_valid = 1'b1;
    tick();
    k = cyc;
    chk("accept_ready_drop", rdy, 1'b0);
    tick();
    chk("wr41_db", db, 8'h41);
    chk("wr41_rs", rs, 1'b1);
    chk("wr41_en_k1", en, 1'b0);
    tick();
    chk("wr41_en_k2", en, 1'b1);
    tick();
    chk("wr41_en_k3", en, 1'b0);
    nstb = 0;
    while (rdy !== 1'b1 && (cyc - k) < 200) begin
      tick();
      if (en === 1'b1) nstb++;
    end
    cmd_valid = 1'b0;
    chk("wr41_latency", cyc - k, 44);
    chk("wr41_no_double", nstb, 0);

    do_cmd(1'b0, 8'h01, lat, nstb, db_a, db_b, gap, low_seen, rs_a);
    chk("clear_latency", lat, 1644);
    chk("clear_db", db_a, 8'h01);
    chk("clear_rs", rs_a, 1'b0);
    do_cmd(1'b1, 8'h01, lat, nstb, db_a, db_b, gap, low_seen, rs_a);
    chk("data01_latency", lat, 44);
    chk("data01_strobes", nstb, 1);
    chk("idle_db_hold", db, 8'h01);

    // Reset while the enable strobe is high
    cmd_rs = 1'b1; cmd_data = 8'h55; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_en", en, 1'b1);
    rst8 = 1'b1;
    tick();
    chk("midrst_en", en, 1'b0);
    chk("midrst_ready", rdy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_rs", rs, 1'b0);
    rst8 = 1'b0;
    seen = 1'b0;
    repeat (15000) begin
      tick();
      if (en === 1'b1) seen = 1'b1;
    end
    chk("repwr_quiet", seen, 1'b0);
    wait_en(10, n);
    chk("repwr_strobe_due", (n >= 1 && n <= 3), 1'b1);
    chk("repwr_db", db, 8'h30);

    // ---------------- 4-bit instance ----------------
    rst8 = 1'b1;
    sel4 = 1'b1;
    tick();
    rst4 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wait_en(20000, n);
      chk($sformatf("nib%0d", i), db[7:4], exp4[i]);
      chk($sformatf("nib%0d_low", i), db[3:0], 4'h0);
      tick();
    end
    wait_rdy(100, n);
    chk("b4_ready", rdy, 1'b1);
    chk("b4_done", done, 1'b1);

    do_cmd(1'b1, 8'hA5, lat, nstb, db_a, db_b, gap, low_seen, rs_a);
    chk("a5_strobes", nstb, 2);
    chk("a5_hi", db_a, 8'hA0);
    chk("a5_lo", db_b, 8'h50);
    chk("a5_gap", gap, 4);
    chk("a5_low_bits", low_seen, 1'b0);
    chk("a5_rs", rs_a, 1'b1);
    chk("a5_latency", lat, 48);
    chk("b4_rw", rw, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
